// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates conditional branches and jumps one cycle after
// issue, reports the corrected next PC and mispredict status, and trains a
// table of 2-bit saturating predictor counters that fetch can look up
// combinationally.
// Optional feature macro: BRU_PERF_CNT_EN adds branch/mispredict performance
// counters. Without it both counter outputs are tied to zero and no counter
// flops exist.

package branch_resolve_unit_pkg;
  typedef enum logic [3:0] {
    BEQ  = 4'd0,
    BNE  = 4'd1,
    BLT  = 4'd2,
    BLTU = 4'd3,
    BGE  = 4'd4,
    BGEU = 4'd5,
    JAL  = 4'd6,
    JALR = 4'd7,
    NOP  = 4'd8
  } fu_op_t;
endpackage

module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  fu_op_t          operator_i,
  input  logic [XLEN-1:0] operand_1_i,
  input  logic [XLEN-1:0] operand_2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_addr_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            lookup_taken_o,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic            taken_o,
  output logic            instr_jump_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic [XLEN-1:0] link_addr_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic            isCond;
  logic            isJump;
  logic            condTaken;
  logic            taken;
  logic            mispred;
  logic            accept;
  logic [XLEN-1:0] branchTarget;
  logic [XLEN-1:0] jalrTarget;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] linkAddr;
  logic [XLEN-1:0] jumpAddr;

  logic [IDX_W-1:0] updIdx;
  logic [IDX_W-1:0] lookupIdx;
  logic [1:0]       cntCur;
  logic [1:0]       cntNext;
  logic [1:0]       bht_q [BHT_ENTRIES];

  logic            resValid_q;
  logic            resValid_d;
  logic            taken_q;
  logic            instrJump_q;
  logic            mispred_q;
  logic [XLEN-1:0] jumpAddr_q;
  logic [XLEN-1:0] linkAddr_q;

  // Only the index bits of the fetch lookup PC select a counter.
  logic unusedLookupBits;
  assign unusedLookupBits = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0]};

  // Decode the operator and evaluate the branch condition from the raw operands.
  always_comb begin
    isCond    = 1'b0;
    isJump    = 1'b0;
    condTaken = 1'b0;
    case (operator_i)
      BEQ: begin
        isCond    = 1'b1;
        condTaken = (operand_1_i == operand_2_i);
      end
      BNE: begin
        isCond    = 1'b1;
        condTaken = (operand_1_i != operand_2_i);
      end
      BLT: begin
        isCond    = 1'b1;
        condTaken = ($signed(operand_1_i) < $signed(operand_2_i));
      end
      BGE: begin
        isCond    = 1'b1;
        condTaken = !($signed(operand_1_i) < $signed(operand_2_i));
      end
      BLTU: begin
        isCond    = 1'b1;
        condTaken = (operand_1_i < operand_2_i);
      end
      BGEU: begin
        isCond    = 1'b1;
        condTaken = !(operand_1_i < operand_2_i);
      end
      JAL, JALR: isJump = 1'b1;
      default: ;
    endcase
  end

  assign branchTarget = pc_i + imm_i;
  assign jalrTarget   = (operand_1_i + imm_i) & ~XLEN'(1);
  assign target       = (operator_i == JALR) ? jalrTarget : branchTarget;
  assign linkAddr     = pc_i + XLEN'(4);
  assign taken        = isJump | (isCond & condTaken);
  assign jumpAddr     = taken ? target : linkAddr;
  assign mispred      = (isCond | isJump) &
                        ((taken != pred_taken_i) | (taken & (target != pred_addr_i)));

  assign ready_o = (!resValid_q || res_ready_i) && !flush_i;
  assign accept  = valid_i && ready_o;

  // Result-valid next state: flush wins, then a new accept, then consumption.
  always_comb begin
    resValid_d = resValid_q;
    if (flush_i) begin
      resValid_d = 1'b0;
    end else if (accept) begin
      resValid_d = 1'b1;
    end else if (res_ready_i) begin
      resValid_d = 1'b0;
    end
  end

  // Result registers load only on accept so a stalled result stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resValid_q  <= 1'b0;
      taken_q     <= 1'b0;
      instrJump_q <= 1'b0;
      mispred_q   <= 1'b0;
      jumpAddr_q  <= '0;
      linkAddr_q  <= '0;
    end else begin
      resValid_q <= resValid_d;
      if (accept) begin
        taken_q     <= taken;
        instrJump_q <= isJump;
        mispred_q   <= mispred;
        jumpAddr_q  <= jumpAddr;
        linkAddr_q  <= linkAddr;
      end
    end
  end

  assign res_valid_o  = resValid_q;
  assign taken_o      = taken_q;
  assign instr_jump_o = instrJump_q;
  assign mispredict_o = mispred_q;
  assign jump_addr_o  = jumpAddr_q;
  assign link_addr_o  = linkAddr_q;

  assign updIdx         = pc_i[IDX_W+1:2];
  assign lookupIdx      = lookup_pc_i[IDX_W+1:2];
  assign cntCur         = bht_q[updIdx];
  assign lookup_taken_o = bht_q[lookupIdx][1];

  // Saturating counter step toward the resolved direction.
  always_comb begin
    cntNext = cntCur;
    if (condTaken && cntCur != 2'd3) begin
      cntNext = cntCur + 2'd1;
    end else if (!condTaken && cntCur != 2'd0) begin
      cntNext = cntCur - 2'd1;
    end
  end

  // Predictor table trains only on accepted conditional branches; the lookup
  // reads the flops directly, so a same-cycle update is not visible yet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (accept && isCond) begin
      bht_q[updIdx] <= cntNext;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branchCnt_q;
  logic [31:0] mispredCnt_q;

  // Count accepted branches/jumps and their mispredicts; both wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branchCnt_q  <= '0;
      mispredCnt_q <= '0;
    end else if (accept && (isCond || isJump)) begin
      branchCnt_q <= branchCnt_q + 32'd1;
      if (mispred) begin
        mispredCnt_q <= mispredCnt_q + 32'd1;
      end
    end
  end

  assign branch_cnt_o  = branchCnt_q;
  assign mispred_cnt_o = mispredCnt_q;
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard testbench for branch_resolve_unit: a driver issues directed and
// random instructions and pushes reference results into a queue; a monitor
// pops and compares whenever the unit presents a result.
// Honours BRU_PERF_CNT_EN for the expected performance counter values.

module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int NENT = 64;

  typedef struct {
    fu_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] pa;
    logic        valid;
    logic        rready;
    logic        flush;
    logic [31:0] lpc;
  } stim_t;

  typedef struct {
    logic        taken;
    logic        jump;
    logic        mispred;
    logic [31:0] jaddr;
    logic [31:0] laddr;
  } exp_t;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  fu_op_t      operator_i;
  logic [31:0] operand_1_i;
  logic [31:0] operand_2_i;
  logic [31:0] imm_i;
  logic [31:0] pc_i;
  logic        pred_taken_i;
  logic [31:0] pred_addr_i;
  logic        flush_i;
  logic [31:0] lookup_pc_i;
  logic        lookup_taken_o;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        taken_o;
  logic        instr_jump_o;
  logic        mispredict_o;
  logic [31:0] jump_addr_o;
  logic [31:0] link_addr_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int          compared   = 0;
  int          mismatched = 0;
  exp_t        expQ[$];
  logic        modelValid;
  logic        dropHeld;
  int          bhtModel[NENT];
  logic [31:0] modelBrCnt;
  logic [31:0] modelMpCnt;

  branch_resolve_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .operator_i    (operator_i),
    .operand_1_i   (operand_1_i),
    .operand_2_i   (operand_2_i),
    .imm_i         (imm_i),
    .pc_i          (pc_i),
    .pred_taken_i  (pred_taken_i),
    .pred_addr_i   (pred_addr_i),
    .flush_i       (flush_i),
    .lookup_pc_i   (lookup_pc_i),
    .lookup_taken_o(lookup_taken_o),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .taken_o       (taken_o),
    .instr_jump_o  (instr_jump_o),
    .mispredict_o  (mispredict_o),
    .jump_addr_o   (jump_addr_o),
    .link_addr_o   (link_addr_o),
    .branch_cnt_o  (branch_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic isCondOp(input fu_op_t op);
    return op inside {BEQ, BNE, BLT, BLTU, BGE, BGEU};
  endfunction

  function automatic logic isJumpOp(input fu_op_t op);
    return op inside {JAL, JALR};
  endfunction

  // Reference result straight from the architectural branch rules.
  function automatic exp_t refResolve(input stim_t s);
    exp_t        e;
    logic [31:0] tgt;
    e.taken = 1'b0;
    case (s.op)
      BEQ:       e.taken = (s.a == s.b);
      BNE:       e.taken = (s.a != s.b);
      BLT:       e.taken = ($signed(s.a) < $signed(s.b));
      BGE:       e.taken = ($signed(s.a) >= $signed(s.b));
      BLTU:      e.taken = (s.a < s.b);
      BGEU:      e.taken = (s.a >= s.b);
      JAL, JALR: e.taken = 1'b1;
      default:   e.taken = 1'b0;
    endcase
    tgt       = (s.op == JALR) ? ((s.a + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);
    e.jump    = isJumpOp(s.op);
    e.laddr   = s.pc + 32'd4;
    e.jaddr   = e.taken ? tgt : e.laddr;
    e.mispred = (isCondOp(s.op) || isJumpOp(s.op)) &&
                ((e.taken != s.pt) || (e.taken && tgt != s.pa));
    return e;
  endfunction

  function automatic int bhtIndex(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  task automatic resetModel();
    expQ.delete();
    modelValid = 1'b0;
    dropHeld   = 1'b0;
    modelBrCnt = '0;
    modelMpCnt = '0;
    for (int i = 0; i < NENT; i++) bhtModel[i] = 1;
  endtask

  task automatic applyStimulus(input stim_t s);
    operator_i   = s.op;
    operand_1_i  = s.a;
    operand_2_i  = s.b;
    imm_i        = s.imm;
    pc_i         = s.pc;
    pred_taken_i = s.pt;
    pred_addr_i  = s.pa;
    valid_i      = s.valid;
    res_ready_i  = s.rready;
    flush_i      = s.flush;
    lookup_pc_i  = s.lpc;
  endtask

  function automatic stim_t mk(input fu_op_t op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic pt, input logic [31:0] pa);
    stim_t s;
    s.op = op; s.a = a; s.b = b; s.imm = imm; s.pc = pc; s.pt = pt; s.pa = pa;
    s.valid = 1'b1; s.rready = 1'b1; s.flush = 1'b0; s.lpc = pc;
    return s;
  endfunction

  function automatic stim_t idle(input logic [31:0] lpc);
    stim_t s;
    s = mk(NOP, 0, 0, 0, 0, 1'b0, 0);
    s.valid = 1'b0;
    s.lpc   = lpc;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t       s;
    logic [31:0] r;
    s.op  = fu_op_t'(4'($urandom_range(0, 11)));
    s.a   = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 8) - 4);
    case ($urandom_range(0, 2))
      0:       s.b = s.a;
      1:       s.b = $urandom;
      default: s.b = $urandom_range(0, 8) - 4;
    endcase
    r      = $urandom;
    s.imm  = {{20{r[11]}}, r[11:0]};
    s.pc   = 32'h0000_1000 + ($urandom_range(0, 15) << 2);
    s.pt   = 1'($urandom_range(0, 1));
    s.pa   = ($urandom_range(0, 1) == 1) ? (s.pc + s.imm) : $urandom;
    s.valid  = ($urandom_range(0, 3) != 0);
    s.flush  = ($urandom_range(0, 11) == 0);
    s.rready = s.flush ? 1'b0 : ($urandom_range(0, 3) != 0);
    s.lpc    = ($urandom_range(0, 1) == 1) ? s.pc : (32'h0000_1000 + ($urandom_range(0, 15) << 2));
    return s;
  endfunction

  // One clock cycle: drive after the edge, check handshake/lookup/counters,
  // then record what the coming edge will do to the reference state.
  task automatic runCycle(input stim_t s);
    exp_t        e;
    logic        expReady;
    logic        accepted;
    int          ui;
    logic [31:0] expBr;
    logic [31:0] expMp;
    @(posedge clk_i);
    #1;
    if (dropHeld) begin
      if (expQ.size() > 0) e = expQ.pop_front();
      dropHeld = 1'b0;
    end
    applyStimulus(s);
    #3;
    checkOutput("res_valid", res_valid_o, modelValid);
    expReady = (!modelValid || s.rready) && !s.flush;
    checkOutput("ready", ready_o, expReady);
    checkOutput("lookup_taken", lookup_taken_o, bhtModel[bhtIndex(s.lpc)] >= 2);
`ifdef BRU_PERF_CNT_EN
    expBr = modelBrCnt;
    expMp = modelMpCnt;
`else
    expBr = '0;
    expMp = '0;
`endif
    checkOutput("branch_cnt", branch_cnt_o, expBr);
    checkOutput("mispred_cnt", mispred_cnt_o, expMp);
    accepted = s.valid && expReady;
    if (accepted) begin
      e = refResolve(s);
      expQ.push_back(e);
      if (isCondOp(s.op)) begin
        ui = bhtIndex(s.pc);
        if (e.taken) bhtModel[ui] = (bhtModel[ui] >= 3) ? 3 : bhtModel[ui] + 1;
        else         bhtModel[ui] = (bhtModel[ui] <= 0) ? 0 : bhtModel[ui] - 1;
      end
      if (isCondOp(s.op) || isJumpOp(s.op)) begin
        modelBrCnt = modelBrCnt + 32'd1;
        if (e.mispred) modelMpCnt = modelMpCnt + 32'd1;
      end
    end
    if (s.flush && modelValid) dropHeld = 1'b1;
    if (s.flush)         modelValid = 1'b0;
    else if (accepted)   modelValid = 1'b1;
    else if (s.rready)   modelValid = 1'b0;
  endtask

  // Monitor: compare the presented result with the scoreboard head, pop on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && res_valid_o) begin
        checkOutput("pending_expected", expQ.size() != 0, 1'b1);
        if (expQ.size() != 0) begin
          e = expQ[0];
          checkOutput("taken", taken_o, e.taken);
          checkOutput("instr_jump", instr_jump_o, e.jump);
          checkOutput("mispredict", mispredict_o, e.mispred);
          checkOutput("jump_addr", jump_addr_o, e.jaddr);
          checkOutput("link_addr", link_addr_o, e.laddr);
          if (res_ready_i) e = expQ.pop_front();
        end
      end
    end
  end

  // Main sequence: reset, directed cases, random traffic, mid-transfer reset, drain.
  initial begin
    stim_t s;
    resetModel();
    rst_ni = 1'b0;
    applyStimulus(idle(32'h40));
    #2;
    checkOutput("rst_res_valid", res_valid_o, 1'b0);
    checkOutput("rst_jump_addr", jump_addr_o, 32'h0);
    checkOutput("rst_link_addr", link_addr_o, 32'h0);
    checkOutput("rst_taken", taken_o, 1'b0);
    checkOutput("rst_lookup", lookup_taken_o, 1'b0);
    checkOutput("rst_branch_cnt", branch_cnt_o, 32'h0);
    checkOutput("rst_mispred_cnt", mispred_cnt_o, 32'h0);
    #10;
    rst_ni = 1'b1;

    runCycle(idle(32'h40));
    runCycle(mk(BEQ, 5, 5, 32'h20, 32'h100, 1'b0, 32'h0));
    runCycle(mk(BLT, 32'hFFFF_FFFF, 1, 32'h40, 32'h200, 1'b0, 32'h0));
    runCycle(mk(BLTU, 32'hFFFF_FFFF, 1, 32'h40, 32'h200, 1'b0, 32'h0));
    runCycle(mk(JALR, 32'h1003, 0, 0, 32'h500, 1'b1, 32'h1002));
    runCycle(mk(JAL, 0, 0, 32'hFFFF_FFF0, 32'h600, 1'b1, 32'h5F0));
    runCycle(idle(32'h40));

    for (int i = 0; i < 5; i++) runCycle(mk(BEQ, 3, 3, 32'h8, 32'h40, 1'b1, 32'h48));
    for (int i = 0; i < 4; i++) runCycle(mk(BNE, 3, 3, 32'h8, 32'h40, 1'b1, 32'h48));
    runCycle(idle(32'h40));

    s = mk(BEQ, 7, 7, 32'h10, 32'h300, 1'b1, 32'h310);
    s.rready = 1'b0;
    runCycle(s);
    for (int i = 1; i <= 3; i++) begin
      s = mk(BNE, 1, 2, 32'h10, 32'h304, 1'b0, 32'h0);
      s.rready = 1'b0;
      s.flush  = (i == 2);
      s.lpc    = 32'h300;
      runCycle(s);
    end
    for (int i = 0; i < 3; i++) runCycle(idle(32'h300));

    for (int i = 0; i < 1500; i++) runCycle(randStim());

    s = mk(BGE, 9, 2, 32'h30, 32'h700, 1'b0, 32'h0);
    s.rready = 1'b0;
    runCycle(s);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    applyStimulus(idle(32'h40));
    #1;
    checkOutput("midrst_res_valid", res_valid_o, 1'b0);
    checkOutput("midrst_jump_addr", jump_addr_o, 32'h0);
    resetModel();
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) runCycle(idle(32'h40));

    for (int i = 0; i < 4; i++) runCycle(idle(32'h1000));
    checkOutput("queue_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
